// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES inverse cipher datapath.
// State byte 0 (FIPS-197 order) sits in element 15, i.e. bits [127:120].
package aes_pkg;

    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } fsm_t;

    function automatic int nr_of(input int key_bits);
        case (key_bits)
            32'd128: return 32'd10;
            32'd192: return 32'd12;
            32'd256: return 32'd14;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] pmul_9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] pmul_b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] pmul_d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] pmul_e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {pmul_e(a0) ^ pmul_b(a1) ^ pmul_d(a2) ^ pmul_9(a3),
                pmul_9(a0) ^ pmul_e(a1) ^ pmul_b(a2) ^ pmul_d(a3),
                pmul_d(a0) ^ pmul_9(a1) ^ pmul_e(a2) ^ pmul_b(a3),
                pmul_b(a0) ^ pmul_d(a1) ^ pmul_9(a2) ^ pmul_e(a3)};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (x & {8{b[i]}});
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = b;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// Combinational InvShiftRows + InvSubBytes; the caller adds the round key.
module aes_inv_round_comb
    import aes_pkg::*;
(
    input  aes_state_t st_in,
    output aes_state_t st_out
);

    // Row r of the result takes column (c - r) mod 4 of the input.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int ROW = i % 4;
        localparam int COL = i / 4;
        localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
        aes_inv_sbox u_sbox (
            .a (st_in[15 - SRC]),
            .y (st_out[15 - i])
        );
    end

endmodule

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = gf_inv(inv_affine(a));

endmodule

// File: rtl/aes_inv_cipher_stream.sv
// Iterative AES inverse cipher, one round per clock, with a loadable round-key
// buffer and valid/ready streaming on both sides.
module aes_inv_cipher_stream
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rk_we,
    input  logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         rk_err,
    output logic         key_rdy,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NR = nr_of(KEY_BITS);
    localparam int NK = NR + 1;

    if (NR == 0) begin : g_bad_key_bits
        $error("aes_inv_cipher_stream: KEY_BITS must be 128, 192 or 256");
    end

    fsm_t         fsm_r;
    logic [3:0]   rcnt_r;
    aes_state_t   blk_r;
    logic [127:0] key_r [NK];
    logic [NK-1:0] mask_r;
    logic         out_valid_r;
    logic [127:0] out_data_r;
    logic         rk_err_r;

    aes_state_t   pre_s;
    logic [127:0] ark_s;
    logic [127:0] mix_s;
    logic         hs_s;
    logic         wr_ok_s;
    logic         load_s;

    assign key_rdy  = &mask_r;
    assign busy     = (fsm_r != IDLE);
    assign in_ready = (fsm_r == IDLE) & key_rdy;
    assign hs_s     = in_valid & in_ready;
    // A handshake in the same cycle makes the core busy, so the write loses.
    assign wr_ok_s  = rk_we & ~busy & ~hs_s & (rk_idx <= 4'(NR));
    assign load_s   = (fsm_r == ROUND) & (rcnt_r == 4'd0) & (~out_valid_r | out_ready);

    assign rk_err    = rk_err_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    aes_inv_round_comb u_round (
        .st_in  (blk_r),
        .st_out (pre_s)
    );

    assign ark_s = pre_s ^ key_r[rcnt_r];

    // InvMixColumns on the key-added state, one 32-bit column at a time.
    always_comb begin
        mix_s = 128'd0;
        for (int c = 0; c < 4; c++) begin
            mix_s[127 - 32 * c -: 32] = inv_mix_col(ark_s[127 - 32 * c -: 32]);
        end
    end

    // Round sequencer: initial key add on accept, middle rounds, then final round or stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_r  <= IDLE;
            rcnt_r <= 4'd0;
            blk_r  <= '0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (hs_s) begin
                        blk_r  <= in_data ^ key_r[NR];
                        rcnt_r <= 4'(NR - 1);
                        fsm_r  <= ROUND;
                    end
                end
                ROUND: begin
                    if (rcnt_r != 4'd0) begin
                        blk_r  <= mix_s;
                        rcnt_r <= rcnt_r - 4'd1;
                    end else if (load_s) begin
                        fsm_r <= IDLE;
                    end
                end
                default: begin
                    fsm_r  <= IDLE;
                    rcnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Output register: a final-round load wins over a same-cycle consumer handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 128'd0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= ark_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Written-slot mask and reject pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_r   <= '0;
            rk_err_r <= 1'b0;
        end else begin
            rk_err_r <= rk_we & ~wr_ok_s;
            if (wr_ok_s) begin
                mask_r[rk_idx] <= 1'b1;
            end
        end
    end

    // Round-key storage; contents are meaningless until the mask says otherwise.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            key_r[rk_idx] <= rk_data;
        end
    end

endmodule
